sat_shift_left_seq: RTL

//  Sequential signed saturating left shifter: cct_output = cct_input * 2^shift_amt, clamped to the

---
 rtl/sat_shift_left_seq_pkg.sv | 21 ++
 rtl/sat_shift_left_seq_if.sv | 23 ++
 rtl/sat_shift_left_seq_shl1.sv | 19 +
 rtl/sat_shift_left_seq.sv | 95 +++++++++
 4 files changed

// File: rtl/sat_shift_left_seq_pkg.sv
// Shared definitions for the saturating shift datapaths: FSM states and the
// signed range limits as functions of the data width.
package sat_shift_left_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Largest positive value of a w-bit two's complement number.
  function automatic longint max_pos(int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  // Bit pattern of the most negative w-bit value (1 followed by zeros).
  function automatic longint max_neg(int w);
    return longint'(1) <<< (w - 1);
  endfunction

endpackage

// File: rtl/sat_shift_left_seq_if.sv
// Start/busy/done handshake and operand/result bus of the saturating left shifter.
interface sat_shift_left_seq_if #(
  parameter int WIDTH   = 8,
  parameter int SHIFT_W = 3
);
  logic               start;
  logic [WIDTH-1:0]   cct_input;
  logic [SHIFT_W-1:0] shift_amt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   cct_output;
  logic               saturated;

  modport master (
    output start, cct_input, shift_amt,
    input  busy, done, cct_output, saturated
  );

  modport slave (
    input  start, cct_input, shift_amt,
    output busy, done, cct_output, saturated
  );
endinterface

// File: rtl/sat_shift_left_seq_shl1.sv
// One step of the saturating left shift: shift by one, or clamp toward the
// operand's sign when the shift would change the sign bit.
module sat_shl1
  import sat_shift_left_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] acc,
  input  logic             sign,
  output logic [WIDTH-1:0] nxt,
  output logic             ovf
);
  localparam logic [WIDTH-1:0] MAX_POS = WIDTH'(max_pos(WIDTH));
  localparam logic [WIDTH-1:0] MAX_NEG = WIDTH'(max_neg(WIDTH));

  // The top two bits differ exactly when doubling leaves the signed range.
  assign ovf = acc[WIDTH-1] ^ acc[WIDTH-2];
  assign nxt = ovf ? (sign ? MAX_NEG : MAX_POS) : {acc[WIDTH-2:0], 1'b0};
endmodule

// File: rtl/sat_shift_left_seq.sv
// Sequential signed saturating left shifter: one bit-shift per clock,
// start/busy/done handshake, result held until the next operation completes.
//
//  state | meaning
//  IDLE  | waiting for start; operands captured on the accepted edge
//  SHIFT | one shift (or clamp) per cycle until count runs out or overflow
//  DONE  | one-cycle done pulse, result registered on entry
module sat_shift_left_seq
  import sat_shift_left_seq_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHIFT_W = 3
) (
  input  logic               clk,
  input  logic               clear,
  sat_shift_left_seq_if.slave bus
);
  state_t             state, state_nxt;
  logic [WIDTH-1:0]   acc;
  logic [SHIFT_W-1:0] cnt;
  logic               sign;
  logic               sat;
  logic [WIDTH-1:0]   out_q;
  logic               sat_q;
  logic [WIDTH-1:0]   step_nxt;
  logic               step_ovf;

  sat_shl1 #(.WIDTH(WIDTH)) u_shl1 (
    .acc  (acc),
    .sign (sign),
    .nxt  (step_nxt),
    .ovf  (step_ovf)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start)
                 state_nxt = (bus.shift_amt == '0) ? DONE : SHIFT;
      SHIFT:   if (step_ovf || cnt == SHIFT_W'(1))
                 state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      acc   <= '0;
      cnt   <= '0;
      sign  <= 1'b0;
      sat   <= 1'b0;
      out_q <= '0;
      sat_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          acc  <= bus.cct_input;
          cnt  <= bus.shift_amt;
          sign <= bus.cct_input[WIDTH-1];
          sat  <= 1'b0;
          // A zero shift goes straight to DONE, so publish the operand now.
          if (bus.shift_amt == '0) begin
            out_q <= bus.cct_input;
            sat_q <= 1'b0;
          end
        end
        SHIFT: begin
          acc <= step_nxt;
          sat <= sat | step_ovf;
          if (!step_ovf)
            cnt <= cnt - SHIFT_W'(1);
          if (state_nxt == DONE) begin
            out_q <= step_nxt;
            sat_q <= sat | step_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
  assign bus.cct_output = out_q;
  assign bus.saturated  = sat_q;
endmodule
